ula_pipe: RTL
=============

ULA_PIPE -- requirements
Module: ula_pipe

Interface
REQ-001 Parameter: W, default 6, operand/result width; legal range 2..32.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: R  input  1  asynchronous, active-high reset; clears all state immediately on assertion.
REQ-004 Port: S  input  5  opcode, sampled with A and B on input handshake.
REQ-005 Port: A, B  input  W each  operands (unsigned unless stated).
REQ-006 Port: IN_VALID  input  1  opcode/operands valid.
REQ-007 Port: IN_READY  output  1  block can accept an operation this cycle.
REQ-008 Port: O  output  W  registered result.
REQ-009 Port: Cout  output  1  registered carry/borrow bit W of the extended result.
REQ-010 Port: Zero  output  1  registered, O == 0.
REQ-011 Port: Neg  output  1  registered, O[W-1].
REQ-012 Port: Ovf  output  1  registered signed overflow (codes 0-7 only, else 0).
REQ-013 Port: Ill  output  1  registered, opcode 21-31 accepted.
REQ-014 Port: OUT_VALID  output  1  O and flags hold a result.
REQ-015 Port: OUT_READY  input  1  consumer takes the result.

Function
REQ-016 Codes 0-15 SHALL compute as the existing 6-bit ULA, widened to W: result = (W+1)-bit {0,A} op {0,X}; O = bits W-1:0, Cout = bit W (borrow=1 when subtrahend > minuend). Ops: 0 A+B, 1 A-B, 2 A+~B, 3 A-~B, 4 A+1, 5 A-1, 6 B+1, 7 B-1, 8 A&B, 9 ~A, 10 ~B, 11 A|B, 12 A^B, 13 ~(A&B), 14 A, 15 B; codes 8-15 give Cout=0.
REQ-017 Ovf for codes 0-7 SHALL be two's-complement overflow of the W-bit signed add/sub actually performed.
REQ-018 Shift amount k = B mod W; code 16 SHL: {Cout,O} = bits W:0 of ({0,A} << k); 17 SHR logical: O = A >> k, Cout=0; 18 ROL by k; 19 ROR by k; rotates Cout=0.
REQ-019 Code 20 MUL: unsigned A*B by iterative shift-and-add, one partial product per cycle; O = low W bits, Cout = 1 iff high W bits nonzero, Ovf=0.
REQ-020 Codes 21-31: O=0, Cout=0, Ovf=0, Zero=1, Ill=1; otherwise Ill=0.
REQ-021 Zero and Neg SHALL always derive from the final O of the same result.
REQ-022 FSM states: IDLE, MUL. IDLE->MUL on accepted code 20; MUL->IDLE after exactly W iteration cycles, loading output registers on that last edge.
REQ-023 IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY); accept occurs on edge with IN_VALID && IN_READY.
REQ-024 Codes other than 20: result and OUT_VALID=1 registered on the accepting edge (latency 1, throughput 1 per cycle back-to-back).
REQ-025 Code 20: accepted at edge t; OUT_VALID rises after edge t+W; IN_READY=0 throughout MUL.
REQ-026 OUT_VALID clears on edge with OUT_READY=1 unless a new result loads on the same edge, in which case OUT_VALID stays 1 with the new result.
REQ-027 While OUT_VALID=1 and OUT_READY=0, O and all flags SHALL remain stable.
REQ-028 Operand changes while IN_READY=0 or IN_VALID=0 SHALL not affect state or outputs.
REQ-029 A result in progress in MUL is lost on R; no partial result is ever presented.

Reset
REQ-030 On R=1: state=IDLE, O=0, Cout=0, Zero=0, Neg=0, Ovf=0, Ill=0, OUT_VALID=0, multiplier registers cleared, asynchronously.
REQ-031 IN_READY SHALL be 0 while R=1 and 1 on the first cycle after R deasserts.

Verification
REQ-032 W=6, S=0, A=63, B=1, OUT_READY=1 -> next cycle O=0, Cout=1, Zero=1, Ovf=0, OUT_VALID=1.
REQ-033 W=6, S=1, A=3, B=5 -> O=62, Cout=1, Neg=1; S=0, A=31, B=1 -> O=32, Ovf=1, Neg=1.
REQ-034 W=6, S=20, A=9, B=7 -> IN_READY=0 for 6 cycles, OUT_VALID after edge t+6, O=63, Cout=0; A=B=63 -> O=1, Cout=1.
REQ-035 W=6, S=16, A=48, B=7 (k=1) -> O=32, Cout=1; S=19, A=1, B=1 -> O=32; S=25 -> O=0, Zero=1, Ill=1.
REQ-036 Backpressure: result pending, OUT_READY=0 for 3 cycles, operands toggling -> O/flags stable, IN_READY=0; OUT_READY=1 with IN_VALID=1 -> new result loads, OUT_VALID stays 1.
REQ-037 Assert R mid-MUL (cycle 3 of 6) -> all outputs 0 immediately, OUT_VALID never rises for that op, IN_READY=1 first cycle after release.

Source files
------------

// File: rtl/ula_pipe.sv
// Pipelined W-bit arithmetic/logic unit: single-cycle ALU, shift and rotate operations,
// plus an iterative shift-and-add multiplier, behind valid/ready handshakes on both sides.
module ula_pipe #(
    parameter int W = 6
) (
    input  logic         CLK,
    input  logic         R,
    input  logic [4:0]   S,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic [W-1:0] O,
    output logic         Cout,
    output logic         Zero,
    output logic         Neg,
    output logic         Ovf,
    output logic         Ill,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic         dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;
    localparam int         CW      = 6;
    localparam logic [4:0] OP_MUL  = 5'd20;
    localparam logic [4:0] OP_ILL  = 5'd21;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] prod_next;

    logic         accept;
    logic         mul_done;

    logic [W-1:0] opa;
    logic [W-1:0] opx;
    logic         is_sub;
    logic [W:0]   arith;
    logic         arith_ovf;
    logic [31:0]  k;
    logic [W:0]   shl;
    logic [W-1:0] rol;
    logic [W-1:0] ror;
    logic [W:0]   ext;
    logic         ovf_c;
    logic         ill_c;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and a producer holds its payload stable until the transfer.
    assign IN_READY  = !R && (state == ST_IDLE) && (!OUT_VALID || OUT_READY);
    assign accept    = IN_VALID && IN_READY;
    assign mul_done  = (state == ST_MUL) && (cnt == CW'(W - 1));
    assign dbg_state = state;

    // First-operand / second-operand selection for the add/sub group (codes 0-7).
    always_comb begin
        opa    = A;
        opx    = B;
        is_sub = 1'b0;
        case (S[2:0])
            3'd0: opx = B;
            3'd1: is_sub = 1'b1;
            3'd2: opx = ~B;
            3'd3: begin
                opx    = ~B;
                is_sub = 1'b1;
            end
            3'd4: opx = {{(W-1){1'b0}}, 1'b1};
            3'd5: begin
                opx    = {{(W-1){1'b0}}, 1'b1};
                is_sub = 1'b1;
            end
            3'd6: begin
                opa = B;
                opx = {{(W-1){1'b0}}, 1'b1};
            end
            default: begin
                opa    = B;
                opx    = {{(W-1){1'b0}}, 1'b1};
                is_sub = 1'b1;
            end
        endcase
    end

    always_comb begin
        if (is_sub) begin
            arith     = {1'b0, opa} - {1'b0, opx};
            arith_ovf = (opa[W-1] != opx[W-1]) && (arith[W-1] != opa[W-1]);
        end else begin
            arith     = {1'b0, opa} + {1'b0, opx};
            arith_ovf = (opa[W-1] == opx[W-1]) && (arith[W-1] != opa[W-1]);
        end
    end

    // Shift amount is B reduced modulo the word width, so rotates never exceed one turn.
    always_comb begin
        k   = 32'(B) % 32'(W);
        shl = {1'b0, A} << k;
        rol = (A << k) | (A >> (32'(W) - k));
        ror = (A >> k) | (A << (32'(W) - k));
    end

    always_comb begin
        ext   = '0;
        ovf_c = 1'b0;
        ill_c = 1'b0;
        if (S <= 5'd7) begin
            ext   = arith;
            ovf_c = arith_ovf;
        end else begin
            case (S)
                5'd8:  ext = {1'b0, A & B};
                5'd9:  ext = {1'b0, ~A};
                5'd10: ext = {1'b0, ~B};
                5'd11: ext = {1'b0, A | B};
                5'd12: ext = {1'b0, A ^ B};
                5'd13: ext = {1'b0, ~(A & B)};
                5'd14: ext = {1'b0, A};
                5'd15: ext = {1'b0, B};
                5'd16: ext = shl;
                5'd17: ext = {1'b0, A >> k};
                5'd18: ext = {1'b0, rol};
                5'd19: ext = {1'b0, ror};
                default: begin
                    ext   = '0;
                    ill_c = (S >= OP_ILL);
                end
            endcase
        end
    end

    assign prod_next = acc + (mplier[0] ? mcand : '0);

    // Multiplier sequencer: one partial product per cycle, W cycles per product.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (S == OP_MUL)) begin
                        state  <= ST_MUL;
                        cnt    <= '0;
                        mcand  <= {{W{1'b0}}, A};
                        mplier <= B;
                        acc    <= '0;
                    end
                end
                default: begin
                    acc    <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (mul_done) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Result register: loads on a finished product or on any accepted non-multiply op,
    // otherwise holds until the consumer takes it.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            O         <= '0;
            Cout      <= 1'b0;
            Zero      <= 1'b0;
            Neg       <= 1'b0;
            Ovf       <= 1'b0;
            Ill       <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (mul_done) begin
            O         <= prod_next[W-1:0];
            Cout      <= |prod_next[2*W-1:W];
            Zero      <= (prod_next[W-1:0] == '0);
            Neg       <= prod_next[W-1];
            Ovf       <= 1'b0;
            Ill       <= 1'b0;
            OUT_VALID <= 1'b1;
        end else if (accept && (S != OP_MUL)) begin
            O         <= ext[W-1:0];
            Cout      <= ext[W];
            Zero      <= (ext[W-1:0] == '0);
            Neg       <= ext[W-1];
            Ovf       <= ovf_c;
            Ill       <= ill_c;
            OUT_VALID <= 1'b1;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule
